frame_readout: RTL and testbench
================================

FRAME_READOUT -- requirements
Module: frame_readout

Interface
REQ-001 SHALL have parameter WIDTH, default 256, frame width in pixels; a multiple of 8, at most 256.
REQ-002 SHALL have parameter HEIGHT, default 256, frame height in lines; at most 256.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, one-cycle request to read out one frame.
REQ-006 SHALL have port busy, output, 1, high from the cycle after start is accepted until done.
REQ-007 SHALL have port done, output, 1, one-cycle pulse after the last byte is accepted.
REQ-008 SHALL have ports rd_x and rd_y, output, 8 each, frame-buffer read coordinates.
REQ-009 SHALL have port rd_en, output, 1, read strobe; frame buffer returns data one cycle later.
REQ-010 SHALL have port rd_value, input, 1, pixel read from the binary threshold frame buffer.
REQ-011 SHALL have port out_data, output, 8, packed pixel byte.
REQ-012 SHALL have ports out_valid (output, 1) and out_ready (input, 1) forming the byte stream handshake.
REQ-013 SHALL have port ones_count, output, 24, number of pixels equal to 1 in the last or current frame, for display on 7-segment.

Function
REQ-014 SHALL implement states IDLE, FETCH, CAPTURE, SEND, DONE.
REQ-015 In IDLE, start=1 SHALL clear ones_count, zero the x/y counters, and enter FETCH; start in any other state SHALL be ignored.
REQ-016 FETCH SHALL last exactly 8 cycles, asserting rd_en with rd_y=y and rd_x=x+k for k=0..7 in successive cycles.
REQ-017 rd_value returned one cycle after each read SHALL be shifted into the byte so that pixel k=0 lands in out_data[7] (MSB-first, left pixel first).
REQ-018 CAPTURE SHALL take one cycle, absorb the 8th returned pixel, and enter SEND; rd_en SHALL be 0 in CAPTURE, SEND, IDLE, and DONE.
REQ-019 Each returned pixel equal to 1 SHALL increment ones_count in the cycle it is captured; ones_count saturates at 24'hFFFFFF.
REQ-020 In SEND, out_valid SHALL be 1 and out_data stable until out_ready=1 is sampled; out_valid SHALL be 0 in all other states.
REQ-021 On handshake, x SHALL advance by 8; when x+8 equals WIDTH, x SHALL wrap to 0 and y advances by 1.
REQ-022 On the handshake of the byte at x=WIDTH-8, y=HEIGHT-1, the block SHALL enter DONE instead of FETCH.
REQ-023 DONE SHALL assert done for one cycle, then return to IDLE; busy SHALL be 0 in IDLE and 1 elsewhere, including DONE.
REQ-024 With out_ready held 1, byte period SHALL be 10 cycles; the first out_valid SHALL occur 10 cycles after the start edge.
REQ-025 A frame SHALL yield exactly WIDTH*HEIGHT/8 bytes, in raster order.
REQ-026 ones_count SHALL hold its final value after DONE until the next accepted start.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, busy=0, done=0, rd_en=0, rd_x=0, rd_y=0, out_valid=0, out_data=0, and ones_count=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame without emitting further bytes or done; start is honoured again on the first edge after release.

Structure
REQ-029 SHALL place the state encoding and the FRAME_W/FRAME_H defaults (256) in the shared image package used by the threshold and VGA blocks.
REQ-030 SHALL instantiate one sub-module, pixel_packer, holding the 8-bit shift register and the capture counter.

Verification
REQ-031 SHALL cover a full-frame readout: a model RAM with pixel = x[0]^y[0], WIDTH=HEIGHT=256, and out_ready=1 -> 8192 bytes alternating 8'hAA and 8'h55 per line, ones_count=32768, and one done pulse.
REQ-032 SHALL cover back-pressure: out_ready low for 5 cycles in SEND -> out_valid stays high, out_data is unchanged, and no rd_en occurs until the handshake.
REQ-033 SHALL cover line wrap: WIDTH=16 and HEIGHT=2 -> read order (0..7,0), (8..15,0), (0..7,1), (8..15,1); 4 bytes, then done.
REQ-034 SHALL cover start while busy: a second start pulse mid-frame -> no restart, byte count is unchanged, and ones_count is not cleared.
REQ-035 SHALL cover reset mid-frame: reset asserted during FETCH of byte 3 -> all outputs reach their reset values asynchronously, and a new start yields a full frame beginning at (0,0).
REQ-036 SHALL cover an all-ones frame: every pixel = 1 -> all bytes are 8'hFF and ones_count=65536.

Source files
------------

// File: rtl/frame_readout_pkg.sv
// Shared image package: frame geometry defaults, readout FSM encoding and the
// saturating pixel-count helper used by the threshold, VGA and readout blocks.
package frame_readout_pkg;

    localparam int unsigned FRAME_W = 256;
    localparam int unsigned FRAME_H = 256;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StFetch   = 3'd1;
    localparam logic [2:0] StCapture = 3'd2;
    localparam logic [2:0] StSend    = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;

    localparam logic [23:0] OnesMax = 24'hFFFFFF;

    function automatic logic [23:0] sat_inc(input logic [23:0] v);
        return (v == OnesMax) ? v : v + 24'd1;
    endfunction

endpackage

// File: rtl/frame_readout_pixel_packer.sv
// Packs one-bit pixels returned by the frame buffer into a byte, MSB first.
// The capture strobe is the read strobe delayed by the buffer's one-cycle latency.
module frame_readout_pixel_packer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rd_en_i,
    input  logic       pix_i,
    input  logic       clear_i,
    output logic [7:0] data_o,
    output logic       fire_o,
    output logic       full_o
);

    logic       fire_q;
    logic [7:0] sr_q, sr_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (fire_q) begin
            sr_d  = {sr_q[6:0], pix_i};
            cnt_d = cnt_q + 4'd1;
        end
        if (clear_i) begin
            cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fire_q <= 1'b0;
            sr_q   <= 8'd0;
            cnt_q  <= 4'd0;
        end else begin
            fire_q <= rd_en_i;
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o = sr_q;
    assign fire_o = fire_q;
    assign full_o = (cnt_q == 4'd8);

endmodule

// File: rtl/frame_readout.sv
// Reads a binary threshold frame out of the frame buffer in raster order,
// packing 8 pixels per byte onto a valid/ready stream and counting set pixels.
module frame_readout
    import frame_readout_pkg::*;
#(
    parameter int unsigned WIDTH  = FRAME_W,
    parameter int unsigned HEIGHT = FRAME_H
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rd_x,
    output logic [7:0]  rd_y,
    output logic        rd_en,
    input  logic        rd_value,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] ones_count
);

    // 9 bits so that WIDTH = 256 is representable as the wrap point.
    localparam logic [8:0] XEnd  = 9'(WIDTH);
    localparam logic [7:0] YLast = 8'(HEIGHT - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [2:0]  k_q, k_d;
    logic [23:0] ones_q, ones_d;

    logic       frame_start;
    logic       handshake;
    logic       x_wrap;
    logic       pix_fire;
    logic       byte_full;
    logic [7:0] byte_data;

    assign frame_start = (state_q == StIdle) && start;
    assign handshake   = out_valid && out_ready;
    assign x_wrap      = (({1'b0, x_q} + 9'd8) == XEnd);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        ones_d  = ones_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    x_d     = 8'd0;
                    y_d     = 8'd0;
                    k_d     = 3'd0;
                end
            end
            StFetch: begin
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d = StCapture;
                end
            end
            StCapture: state_d = StSend;
            StSend: begin
                if (handshake) begin
                    state_d = StFetch;
                    if (x_wrap) begin
                        x_d = 8'd0;
                        if (y_q == YLast) begin
                            state_d = StDone;
                            y_d     = 8'd0;
                        end else begin
                            y_d = y_q + 8'd1;
                        end
                    end else begin
                        x_d = x_q + 8'd8;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (frame_start) begin
            ones_d = 24'd0;
        end else if (pix_fire && rd_value) begin
            ones_d = sat_inc(ones_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            k_q     <= 3'd0;
            ones_q  <= 24'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k_q     <= k_d;
            ones_q  <= ones_d;
        end
    end

    frame_readout_pixel_packer pixel_packer (
        .clk_i   (clock),
        .rst_i   (reset),
        .rd_en_i (rd_en),
        .pix_i   (rd_value),
        .clear_i (frame_start || handshake),
        .data_o  (byte_data),
        .fire_o  (pix_fire),
        .full_o  (byte_full)
    );

    assign rd_en      = (state_q == StFetch);
    assign rd_x       = rd_en ? (x_q + {5'd0, k_q}) : 8'd0;
    assign rd_y       = rd_en ? y_q : 8'd0;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign out_valid  = (state_q == StSend) && byte_full;
    assign out_data   = byte_data;
    assign ones_count = ones_q;

endmodule

// File: tb/tb_frame_readout.sv
// Bench for frame_readout: a 64x8 instance for frame content, timing, back-pressure,
// restart and reset cases, plus a 16x2 instance for the line-wrap read order.
module tb_frame_readout;

    localparam int BW = 64;
    localparam int BH = 8;
    localparam int NB = BW * BH / 8;
    localparam int SW = 16;
    localparam int SH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        out_ready = 1'b1;
    logic        rd_value;
    logic        busy, done, rd_en, out_valid;
    logic [7:0]  rd_x, rd_y, out_data;
    logic [23:0] ones_count;

    logic        s_start = 1'b0;
    logic        s_rd_value;
    logic        s_busy, s_done, s_rd_en, s_out_valid;
    logic [7:0]  s_rd_x, s_rd_y, s_out_data;
    logic [23:0] s_ones_count;

    bit mem [BH][BW];
    bit smem [SH][SW];

    logic [7:0]  got[$];
    int          hs_t[$];
    logic [15:0] rd_log[$];
    logic [7:0]  s_got[$];
    logic [15:0] s_reads[$];
    int          cyc_cnt = 0;
    int          start_t = 0;
    int          done_cnt = 0;
    int          s_done_cnt = 0;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    frame_readout #(.WIDTH(BW), .HEIGHT(BH)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_x(rd_x), .rd_y(rd_y), .rd_en(rd_en), .rd_value(rd_value),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ones_count(ones_count)
    );

    frame_readout #(.WIDTH(SW), .HEIGHT(SH)) dut_s (
        .clock(clock), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done),
        .rd_x(s_rd_x), .rd_y(s_rd_y), .rd_en(s_rd_en), .rd_value(s_rd_value),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(1'b1),
        .ones_count(s_ones_count)
    );

    // Frame-buffer models (one-cycle read latency) and stream scoreboards.
    always @(posedge clock) begin
        cyc_cnt <= cyc_cnt + 1;
        if (reset) begin
            rd_value   <= 1'b0;
            s_rd_value <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_value <= mem[int'(rd_y)][int'(rd_x)];
                rd_log.push_back({rd_y, rd_x});
            end
            if (start && !busy) start_t <= cyc_cnt;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                hs_t.push_back(cyc_cnt);
            end
            if (done) done_cnt <= done_cnt + 1;
            if (s_rd_en) begin
                s_rd_value <= smem[int'(s_rd_y)][int'(s_rd_x)];
                s_reads.push_back({s_rd_y, s_rd_x});
            end
            if (s_out_valid) s_got.push_back(s_out_data);
            if (s_done) s_done_cnt <= s_done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int mode);
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++)
                mem[y][x] = (mode == 0) ? bit'((x ^ y) & 1) :
                            (mode == 1) ? 1'b1 : bit'($urandom_range(0, 1));
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        int y;
        int x;
        logic [7:0] b;
        y = i / (BW / 8);
        x = (i % (BW / 8)) * 8;
        for (int k = 0; k < 8; k++) b[7-k] = mem[y][x+k];
        return b;
    endfunction

    function automatic int exp_ones();
        int n;
        n = 0;
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++)
                n += int'(mem[y][x]);
        return (n > 32'hFFFFFF) ? 32'hFFFFFF : n;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_rd_en"}, 32'(rd_en), 0);
        check({tag, "_rd_x"}, 32'(rd_x), 0);
        check({tag, "_rd_y"}, 32'(rd_y), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_data"}, 32'(out_data), 0);
        check({tag, "_ones"}, 32'(ones_count), 0);
    endtask

    task automatic run_frame(input bit rand_ready, input bit bp, input bit restart,
                             output int gb, output int db);
        int cyc;
        bit bp_done;
        bit rs_done;
        logic [7:0] held;
        bp_done = 1'b0;
        rs_done = 1'b0;
        gb = got.size();
        db = done_cnt;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        cyc = 0;
        while (done_cnt == db && cyc < 5000) begin
            if (bp && !bp_done && out_valid && (got.size() - gb) == 2) begin
                held = out_data;
                for (int i = 0; i < 5; i++) begin
                    out_ready = 1'b0;
                    @(negedge clock);
                    check("bp_valid_held", 32'(out_valid), 1);
                    check("bp_data_stable", 32'(out_data), 32'(held));
                    check("bp_no_read", 32'(rd_en), 0);
                end
                bp_done = 1'b1;
            end
            if (restart && !rs_done && (got.size() - gb) == 5 && rd_en) begin
                start = 1'b1;
                @(negedge clock);
                start = 1'b0;
                rs_done = 1'b1;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clock);
            cyc++;
        end
        out_ready = 1'b1;
        check("frame_finished", 32'(done_cnt != db), 1);
        repeat (6) @(negedge clock);
    endtask

    task automatic verify(input string tag, input int gb, input int db);
        int n;
        n = got.size() - gb;
        check({tag, "_nbytes"}, n, NB);
        for (int i = 0; i < NB; i++)
            if (i < n) check({tag, "_byte"}, 32'(got[gb+i]), 32'(exp_byte(i)));
        check({tag, "_ones"}, 32'(ones_count), exp_ones());
        check({tag, "_done_pulses"}, done_cnt - db, 1);
        check({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    initial begin
        int gb;
        int db;
        int rb;
        int bad;
        int cyc;
        logic [7:0] b;

        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clock);

        // Line wrap on the 16x2 instance.
        for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++)
                smem[y][x] = bit'($urandom_range(0, 1));
        @(negedge clock) s_start = 1'b1;
        @(negedge clock) s_start = 1'b0;
        cyc = 0;
        while (s_done_cnt == 0 && cyc < 500) begin
            @(negedge clock);
            cyc++;
        end
        repeat (4) @(negedge clock);
        check("wrap_nreads", s_reads.size(), SW * SH);
        for (int i = 0; i < SW * SH; i++)
            if (i < s_reads.size())
                check("wrap_read_xy", 32'(s_reads[i]), 32'((i / SW) * 256 + (i % SW)));
        check("wrap_nbytes", s_got.size(), SW * SH / 8);
        for (int i = 0; i < SW * SH / 8; i++) begin
            for (int k = 0; k < 8; k++) b[7-k] = smem[i / (SW / 8)][(i % (SW / 8)) * 8 + k];
            if (i < s_got.size()) check("wrap_byte", 32'(s_got[i]), 32'(b));
        end
        check("wrap_done_pulses", s_done_cnt, 1);

        // Checkerboard, out_ready held high: content, latency and byte period.
        fill(0);
        run_frame(1'b0, 1'b0, 1'b0, gb, db);
        verify("checker", gb, db);
        check("checker_line0", 32'(got[gb]), 32'h55);
        check("checker_line1", 32'(got[gb + BW / 8]), 32'hAA);
        check("first_byte_latency", hs_t[gb] - start_t, 10);
        bad = 0;
        for (int i = 1; i < NB; i++)
            if (hs_t[gb+i] - hs_t[gb+i-1] != 10) bad++;
        check("byte_period_violations", bad, 0);

        fill(1);
        run_frame(1'b0, 1'b0, 1'b0, gb, db);
        verify("all_ones", gb, db);

        fill(2);
        run_frame(1'b1, 1'b1, 1'b0, gb, db);
        verify("rand_backpressure", gb, db);

        fill(2);
        run_frame(1'b0, 1'b0, 1'b1, gb, db);
        verify("start_while_busy", gb, db);

        // Reset during the fetch of byte 3.
        fill(2);
        gb = got.size();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        cyc = 0;
        while (!((got.size() - gb) == 3 && rd_en) && cyc < 500) begin
            @(negedge clock);
            cyc++;
        end
        check("mid_fetch_reached", 32'(rd_en), 1);
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_reset");
        repeat (3) @(negedge clock);
        reset = 1'b0;
        gb = got.size();
        db = done_cnt;
        repeat (5) @(negedge clock);
        check("post_reset_no_bytes", got.size() - gb, 0);
        check("post_reset_no_done", done_cnt - db, 0);
        rb = rd_log.size();
        run_frame(1'b0, 1'b0, 1'b0, gb, db);
        verify("after_reset", gb, db);
        check("after_reset_first_read", 32'(rd_log[rb]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
